// File: rtl/vcdl_delay_meter_if.sv
// rtl/vcdl_delay_meter_if.sv - measurement request/response and delay-line bundle
interface vcdl_delay_meter_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             echo;
  logic             launch;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] count;

  modport master (
    output start,
    output echo,
    input  launch,
    input  busy,
    input  done,
    input  timeout,
    input  count
  );

  modport slave (
    input  start,
    input  echo,
    output launch,
    output busy,
    output done,
    output timeout,
    output count
  );
endinterface

// File: rtl/vcdl_delay_meter.sv
// rtl/vcdl_delay_meter.sv - VCDL launch/capture delay meter with run averaging and timeout
module vcdl_delay_meter #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 255,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  vcdl_delay_meter_if.slave io_bus
);
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int RUN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SYNC_COMP = CNT_W'(SYNC_STAGES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RECOVER,
    S_FINISH
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [RUN_W-1:0]       r_run_idx;
  logic [ACC_W-1:0]       r_acc;
  logic                   r_launch;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_timeout;
  logic [CNT_W-1:0]       r_count;

  logic                   w_echo_s;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_abort;
  logic                   w_last_run;
  logic [CNT_W-1:0]       w_sample;

  assign w_echo_s   = r_sync[SYNC_STAGES-1];
  assign w_last_run = (r_run_idx == RUN_LAST);
  // The synchronizer adds SYNC_STAGES-1 cycles beyond the true edge count;
  // an echo that was already high gives a count below that, clamp to zero.
  assign w_sample   = (r_cnt > SYNC_COMP) ? (r_cnt - SYNC_COMP) : '0;

  assign io_bus.launch  = r_launch;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.timeout = r_timeout;
  assign io_bus.count   = r_count;

  // Bring the asynchronous echo into the clk domain through a flop chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], io_bus.echo};
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus accept/capture/abort strobes
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_accept = 1'b1;
          w_next   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (w_echo_s) begin
          w_capture = 1'b1;
          w_next    = S_RECOVER;
        end else if (r_cnt == CNT_LAST) begin
          w_abort = 1'b1;
          w_next  = S_FINISH;
        end
      end
      S_RECOVER: begin
        if (!w_echo_s) begin
          w_next = w_last_run ? S_FINISH : S_LAUNCH;
        end else if (r_cnt == CNT_LAST) begin
          w_abort = 1'b1;
          w_next  = S_FINISH;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Phase cycle counter, run index and delay accumulator
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_run_idx <= '0;
      r_acc     <= '0;
    end else begin
      if ((w_next == r_state) && ((r_state == S_LAUNCH) || (r_state == S_RECOVER))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end

      if (w_accept) begin
        r_run_idx <= '0;
      end else if ((r_state == S_RECOVER) && (w_next == S_LAUNCH)) begin
        r_run_idx <= r_run_idx + RUN_W'(1);
      end

      if (w_accept) begin
        r_acc <= '0;
      end else if (w_capture) begin
        r_acc <= r_acc + ACC_W'(w_sample);
      end
    end
  end

  // Registered outputs; launch/busy/done follow the state being entered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_launch  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_count   <= '0;
    end else begin
      r_launch <= (w_next == S_LAUNCH);
      r_busy   <= (w_next == S_LAUNCH) || (w_next == S_RECOVER);
      r_done   <= (w_next == S_FINISH);

      if (w_accept) begin
        r_timeout <= 1'b0;
      end else if (w_abort) begin
        r_timeout <= 1'b1;
      end

      // Dropping the low AVG_LOG2 accumulator bits is the floor division
      if (w_abort) begin
        r_count <= '1;
      end else if ((r_state == S_RECOVER) && (w_next == S_FINISH)) begin
        r_count <= r_acc[ACC_W-1:AVG_LOG2];
      end
    end
  end
endmodule

// File: tb/tb_vcdl_delay_meter.sv
// tb/tb_vcdl_delay_meter.sv - self-checking bench for vcdl_delay_meter
module tb_vcdl_delay_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  vcdl_delay_meter_if #(.CNT_W(8)) if0 ();
  vcdl_delay_meter_if #(.CNT_W(8)) if1 ();

  vcdl_delay_meter #(.CNT_W(8), .TIMEOUT(255), .AVG_LOG2(0), .SYNC_STAGES(2)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(if0)
  );

  vcdl_delay_meter #(.CNT_W(8), .TIMEOUT(255), .AVG_LOG2(2), .SYNC_STAGES(2)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(if1)
  );

  always #5 clk = ~clk;

  logic       start_r [2];
  logic       echo_r  [2];
  logic       l_launch[2];
  logic       l_busy  [2];
  logic       l_done  [2];
  logic       l_to    [2];
  logic [7:0] l_count [2];

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if0.echo  = echo_r[0];
  assign if1.echo  = echo_r[1];
  assign l_launch[0] = if0.launch;
  assign l_launch[1] = if1.launch;
  assign l_busy[0]   = if0.busy;
  assign l_busy[1]   = if1.busy;
  assign l_done[0]   = if0.done;
  assign l_done[1]   = if1.done;
  assign l_to[0]     = if0.timeout;
  assign l_to[1]     = if1.timeout;
  assign l_count[0]  = if0.count;
  assign l_count[1]  = if1.count;

  // Per-run echo delays: D>=1 edges after launch, 0 = line already high, -1 = no echo
  int runs [2][4];
  int run_n[2];
  bit stuck[2];
  int gen  [2];
  int avg_l2[2];

  // Echo generator state (owned by the echo process)
  int seen_gen[2];
  int run_pos [2];
  int cur_d   [2];
  int ecnt    [2];
  bit e_prev  [2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      echo_r[u] = 1'b0; seen_gen[u] = 0; run_pos[u] = 0;
      cur_d[u] = -1; ecnt[u] = 0; e_prev[u] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        if (gen[u] != seen_gen[u]) begin
          seen_gen[u] = gen[u];
          run_pos[u]  = 0;
        end
        if (l_launch[u] && !e_prev[u]) begin
          cur_d[u] = (run_pos[u] < run_n[u]) ? runs[u][run_pos[u]] : -1;
          run_pos[u]++;
          ecnt[u] = 0;
        end else if (l_launch[u]) begin
          ecnt[u]++;
        end
        if (l_launch[u]) begin
          if (cur_d[u] >= 1 && ecnt[u] == cur_d[u] - 1) echo_r[u] = 1'b1;
        end else if (!stuck[u]) begin
          echo_r[u] = (run_pos[u] < run_n[u]) && (runs[u][run_pos[u]] == 0);
        end
        e_prev[u] = l_launch[u];
      end
    end
  end

  // Model and monitor state (owned by the test process)
  int n_pass  = 0;
  int n_total = 0;
  int exp_count[2], exp_to[2], exp_launch[2];
  int held_c[2], held_t[2];
  bit meas_active[2];
  int launches[2], last_launches[2], hi_len[2], last_hi[2], done_seen[2];
  bit m_prev[2];

  task automatic check(input string name, input int u, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d", name, u, act, exp);
  endtask

  // Expected result of one measurement from the run list
  function automatic void model(input int u);
    int n;
    int sum;
    n = 1 << avg_l2[u];
    sum = 0;
    exp_to[u] = 0;
    exp_launch[u] = 0;
    for (int i = 0; i < n; i++) begin
      exp_launch[u]++;
      if (i >= run_n[u] || runs[u][i] < 0) begin
        exp_to[u] = 1;
        break;
      end
      sum += runs[u][i];
      if (stuck[u]) begin
        exp_to[u] = 1;
        break;
      end
    end
    exp_count[u] = exp_to[u] ? 255 : (sum >> avg_l2[u]);
  endfunction

  // One clock: sample at the falling edge and compare both DUTs to the model
  task automatic tick();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        held_c[u] = 0; held_t[u] = 0; meas_active[u] = 1'b0;
        launches[u] = 0; hi_len[u] = 0; m_prev[u] = 1'b0;
      end else begin
        if (l_launch[u] && !m_prev[u]) launches[u]++;
        if (l_launch[u]) hi_len[u]++;
        else if (m_prev[u]) begin
          last_hi[u] = hi_len[u];
          hi_len[u]  = 0;
        end
        m_prev[u] = l_launch[u];
        if (l_done[u]) begin
          check("done_expected", u, int'(meas_active[u]), 1);
          check("count", u, int'(l_count[u]), exp_count[u]);
          check("timeout", u, int'(l_to[u]), exp_to[u]);
          check("busy_at_done", u, int'(l_busy[u]), 0);
          check("launch_pulses", u, launches[u], exp_launch[u]);
          held_c[u] = exp_count[u];
          held_t[u] = exp_to[u];
          meas_active[u] = 1'b0;
          last_launches[u] = launches[u];
          launches[u] = 0;
          done_seen[u]++;
        end else begin
          check("busy", u, int'(l_busy[u]), int'(meas_active[u]));
          check("count_hold", u, int'(l_count[u]), held_c[u]);
          check("timeout_hold", u, int'(l_to[u]), meas_active[u] ? 0 : held_t[u]);
          if (!meas_active[u]) check("launch_idle", u, int'(l_launch[u]), 0);
        end
      end
    end
  endtask

  task automatic load_runs(input int u, input int n, input int d0, input int d1,
                           input int d2, input int d3, input bit stk);
    runs[u][0] = d0; runs[u][1] = d1; runs[u][2] = d2; runs[u][3] = d3;
    run_n[u] = n;
    stuck[u] = stk;
    gen[u]++;
    model(u);
    repeat (5) tick();
  endtask

  task automatic wait_done(input int u, input int budget, input int pulse_at);
    int d0;
    bit got;
    d0 = done_seen[u];
    got = 1'b0;
    for (int i = 1; i <= budget && !got; i++) begin
      start_r[u] = (pulse_at > 0) && (i == pulse_at || i == pulse_at + 20);
      tick();
      start_r[u] = 1'b0;
      if (done_seen[u] != d0) got = 1'b1;
    end
    if (!got) check("done_within_budget", u, 0, 1);
  endtask

  task automatic measure(input int u, input int pulse_at);
    meas_active[u] = 1'b1;
    start_r[u] = 1'b1;
    tick();
    start_r[u] = 1'b0;
    wait_done(u, 700, pulse_at);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      start_r[u] = 1'b0; stuck[u] = 1'b0; gen[u] = 0; run_n[u] = 0;
      held_c[u] = 0; held_t[u] = 0; meas_active[u] = 1'b0; launches[u] = 0;
      last_launches[u] = 0; hi_len[u] = 0; last_hi[u] = 0; done_seen[u] = 0; m_prev[u] = 1'b0;
      for (int i = 0; i < 4; i++) runs[u][i] = 0;
    end
    avg_l2[0] = 0;
    avg_l2[1] = 2;

    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      check("rst_launch", u, int'(l_launch[u]), 0);
      check("rst_busy", u, int'(l_busy[u]), 0);
      check("rst_done", u, int'(l_done[u]), 0);
      check("rst_timeout", u, int'(l_to[u]), 0);
      check("rst_count", u, int'(l_count[u]), 0);
    end
    rst = 1'b0;
    repeat (2) tick();

    // Single shot, echo 5 edges after launch
    load_runs(0, 1, 5, 0, 0, 0, 1'b0);
    measure(0, 0);
    check("lit_single_count", 0, int'(l_count[0]), 5);
    check("lit_single_to", 0, int'(l_to[0]), 0);
    check("lit_single_launches", 0, last_launches[0], 1);
    repeat (10) tick();

    // Minimum delay
    load_runs(0, 1, 1, 0, 0, 0, 1'b0);
    measure(0, 0);
    check("lit_min_count", 0, int'(l_count[0]), 1);

    // Line already high at start: saturates to zero, no error
    load_runs(0, 1, 0, 0, 0, 0, 1'b0);
    measure(0, 0);
    check("lit_stale_count", 0, int'(l_count[0]), 0);
    check("lit_stale_to", 0, int'(l_to[0]), 0);

    // Echo never arrives
    load_runs(0, 1, -1, 0, 0, 0, 1'b0);
    measure(0, 0);
    check("lit_low_count", 0, int'(l_count[0]), 255);
    check("lit_low_to", 0, int'(l_to[0]), 1);
    check("lit_low_launch_len", 0, last_hi[0], 255);

    // Averaging 4,5,5,7 with extra starts while busy
    load_runs(1, 4, 4, 5, 5, 7, 1'b0);
    measure(1, 10);
    check("lit_avg_count", 1, int'(l_count[1]), 5);
    check("lit_avg_launches", 1, last_launches[1], 4);
    repeat (10) tick();

    // Floor of 7/4
    load_runs(1, 4, 1, 2, 2, 2, 1'b0);
    measure(1, 0);
    check("lit_floor_count", 1, int'(l_count[1]), 1);

    // Third run never echoes
    load_runs(1, 3, 3, 4, -1, 0, 1'b0);
    measure(1, 0);
    check("lit_avg_abort_count", 1, int'(l_count[1]), 255);
    check("lit_avg_abort_launches", 1, last_launches[1], 3);

    // Echo stuck high after the first capture
    load_runs(0, 1, 3, 0, 0, 0, 1'b1);
    measure(0, 0);
    check("lit_stuck_count", 0, int'(l_count[0]), 255);
    check("lit_stuck_to", 0, int'(l_to[0]), 1);
    check("lit_stuck_busy", 0, int'(l_busy[0]), 0);

    // Reset in the middle of a launch phase, after an ignored extra start
    load_runs(0, 1, 20, 0, 0, 0, 1'b0);
    meas_active[0] = 1'b1;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (3) tick();
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (3) tick();
    check("pre_rst_launch", 0, int'(l_launch[0]), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_launch", 0, int'(l_launch[0]), 0);
    check("async_rst_busy", 0, int'(l_busy[0]), 0);
    check("async_rst_done", 0, int'(l_done[0]), 0);
    check("async_rst_timeout", 0, int'(l_to[0]), 0);
    check("async_rst_count", 0, int'(l_count[0]), 0);
    check("async_rst_count1", 1, int'(l_count[1]), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    load_runs(0, 1, 3, 0, 0, 0, 1'b0);
    measure(0, 0);
    check("lit_post_rst_count", 0, int'(l_count[0]), 3);
    check("lit_post_rst_launches", 0, last_launches[0], 1);
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vcdl_delay_meter.md
Name: vcdl_delay_meter

Overview:
- Digital launch/capture end of the voltage-controlled delay line (VCDL).
- Drives a launch edge into the line input, receives the asynchronous echo from the line output, and counts clock cycles from launch to echo.
- Repeats the measurement 2^AVG_LOG2 times, averages, and reports the result with a done pulse; a timeout flags a broken or overly long line.
- Sits between the TT top-level I/O mux and the analog VCDL macro.

Parameters:
- CNT_W, 8: width of per-run cycle counter and of reported count.
- TIMEOUT, 255: max cycles per phase before abort; must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W-1.
- AVG_LOG2, 2: log2 of runs averaged per measurement (0 = single shot).
- SYNC_STAGES, 2: flip-flops in echo synchronizer (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active high
- start  input  1  one-cycle request to begin a measurement; sampled only in IDLE
- echo  input  1  delay-line output, asynchronous to clk
- launch  output  1  delay-line input, registered
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse when count/timeout are valid
- timeout  output  1  sticky error flag for last measurement
- count  output  CNT_W  averaged delay in clk cycles, synchronizer-compensated

Behaviour:
- Reset (async assert, sync release): state=IDLE; launch=0, busy=0, done=0, timeout=0, count=0; synchronizer, counters, accumulator cleared. Reset mid-run drops launch immediately.
- echo passes through SYNC_STAGES flops → echo_s. FSM uses only echo_s.
- IDLE:
  - start=1 → LAUNCH next edge; busy=1, run_idx=0, acc=0, timeout=0.
  - start while busy is ignored (no queueing).
- LAUNCH:
  - launch=1; cnt=0 on first cycle, +1 per cycle.
  - echo_s=1 → sample = cnt-(SYNC_STAGES-1), saturating at 0; acc += sample; go RECOVER.
  - cnt reaches TIMEOUT-1 with echo_s=0 → abort: timeout=1, count=all ones, go FINISH.
- RECOVER:
  - launch=0; cnt restarts at 0.
  - echo_s=0 → if run_idx == 2^AVG_LOG2-1 go FINISH, else run_idx++ and go LAUNCH.
  - echo_s stuck high for TIMEOUT cycles → abort as above.
- FINISH (one cycle):
  - done=1, busy=0.
  - count = acc >> AVG_LOG2 (floor) unless aborted; acc width CNT_W+AVG_LOG2, no overflow possible.
  - Return to IDLE.
- count and timeout hold until the next accepted start. timeout clears on accept; count is unchanged until FINISH.
- Echo already high when start accepted: first LAUNCH sees echo_s=1 on cycle 0 → sample 0 (saturation), no error. Bench must not rely on this; it documents a stale line.
- Latency definition: if echo is first sampled high at the D-th rising edge after the edge that raised launch (D≥1), sample = D.
- start and abort never coincide (start only sampled in IDLE); done asserts exactly once per accepted start.

Test Plan:
- Single shot, AVG_LOG2=0; bench echo = launch delayed 5 edges → one done pulse, count=5, timeout=0, launch toggled exactly once.
- Averaging, AVG_LOG2=2; per-run delays 4,5,5,7 → acc=21, count=5, four launch pulses, done after the 4th RECOVER.
- Echo tied low → launch stays high TIMEOUT cycles then drops; done, timeout=1, count=255.
- Echo held high after first capture (stuck) → RECOVER aborts after TIMEOUT cycles; timeout=1, count=255, busy=0.
- start pulses while busy plus rst asserted mid-LAUNCH → extra starts ignored; on rst, launch=0 asynchronously, all outputs 0, next start measures normally (delay 3 → count=3).
- Minimum delay: echo sampled high 1 edge after launch → count=1; echo already high at start → count=0, timeout=0.
